data_nout: RTL and testbench

DATA_NOUT -- requirements
Module: data_nout

---
 rtl/data_nout.sv | 102 ++++++++++
 tb/tb_data_nout.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_nout.sv
// Parallel-to-serial converter: accepts one W*N-bit word and emits N registered W-bit beats
// over a valid/ready stream, with a one-word hold slot so input and output can overlap.
module data_nout #(
  parameter int unsigned W         = 8,
  parameter int unsigned N         = 5,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic           pclk,
  input  logic           rst,
  input  logic [W*N-1:0] din,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   dout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last
);

  localparam int unsigned DW = W * N;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e          state_q;
  logic [DW-1:0]   sr_q;
  logic [DW-1:0]   hr_q;
  logic            hr_full_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    dout_q;
  logic            out_valid_q;
  logic            out_last_q;

  logic            accept;
  logic            beat;
  logic            last_beat;
  logic            sr_free;
  logic            load_sr;
  logic [DW-1:0]   load_word;

  function automatic logic [W-1:0] first_beat(input logic [DW-1:0] word);
    return MSB_FIRST ? word[DW-1 -: W] : word[W-1:0];
  endfunction

  // sr_q keeps only the beats not yet presented, aligned so the next one sits at the head.
  function automatic logic [DW-1:0] drop_beat(input logic [DW-1:0] word);
    return MSB_FIRST ? (word << W) : (word >> W);
  endfunction

  always_comb begin
    accept    = in_valid & in_ready;
    beat      = out_valid_q & out_ready;
    last_beat = beat & (cnt_q == CW'(N - 1));
    sr_free   = (state_q == StIdle) | last_beat;
    load_sr   = sr_free & (hr_full_q | accept);
    load_word = hr_full_q ? hr_q : din;
  end

  assign in_ready  = ~hr_full_q & ~rst;
  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      hr_q        <= '0;
      hr_full_q   <= 1'b0;
      cnt_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (load_sr) begin
        state_q     <= StShift;
        sr_q        <= drop_beat(load_word);
        dout_q      <= first_beat(load_word);
        cnt_q       <= '0;
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b0;
      end else if (last_beat) begin
        state_q     <= StIdle;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else if (beat) begin
        sr_q       <= drop_beat(sr_q);
        dout_q     <= first_beat(sr_q);
        cnt_q      <= cnt_q + CW'(1);
        out_last_q <= (cnt_q == CW'(N - 2));
      end

      // accept implies HR empty, so a word goes to HR only when SR cannot take it.
      if (sr_free & hr_full_q) begin
        hr_full_q <= 1'b0;
      end else if (accept & ~sr_free) begin
        hr_q      <= din;
        hr_full_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_nout.sv
// Bench for data_nout: MSB- and LSB-first instances share stimulus and are checked against a
// queue of expected beats, plus directed sequences with literal expectations.
module tb_data_nout;

  localparam int W = 8;
  localparam int N = 5;

  logic            pclk = 1'b0;
  logic            rst = 1'b1;
  logic [W*N-1:0]  din = '0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready_m, in_ready_l;
  logic            out_valid_m, out_valid_l;
  logic            out_last_m, out_last_l;
  logic [W-1:0]    dout_m, dout_l;

  data_nout #(.W(W), .N(N), .MSB_FIRST(1'b1)) u_msb (
    .pclk(pclk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready_m),
    .dout(dout_m), .out_valid(out_valid_m), .out_ready(out_ready), .out_last(out_last_m)
  );

  data_nout #(.W(W), .N(N), .MSB_FIRST(1'b0)) u_lsb (
    .pclk(pclk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready_l),
    .dout(dout_l), .out_valid(out_valid_l), .out_ready(out_ready), .out_last(out_last_l)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic       last;
    logic [7:0] m;
    logic [7:0] l;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    mon_words;
  int    n_checks = 0;
  int    n_fail = 0;

  logic [7:0] e1m[5]  = '{8'h12, 8'h55, 8'h66, 8'h78, 8'h90};
  logic [7:0] e1l[5]  = '{8'h90, 8'h78, 8'h66, 8'h55, 8'h12};
  logic [7:0] e2m[10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                          8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
  logic [7:0] e2l[10] = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01,
                          8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic expect_beat(input string nm, input logic [7:0] em, input logic [7:0] el,
                             input logic lst);
    chk({nm, "_valid"}, {out_valid_m, out_valid_l}, 2'b11);
    chk({nm, "_dout_msb"}, dout_m, em);
    chk({nm, "_dout_lsb"}, dout_l, el);
    chk({nm, "_last"}, {out_last_m, out_last_l}, {lst, lst});
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic drain(input string nm);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge pclk);
      if (!out_valid_m && !out_valid_l && exp_q.size() == 0) break;
    end
    chk({nm, "_drain_timeout"}, (i < 100), 1'b1);
  endtask

  // Model: every accepted word becomes N expected beats; each transfer consumes one.
  always @(negedge pclk) begin
    if (!rst) begin
      mon_words = (exp_q.size() + N - 1) / N;
      chk("in_ready_msb", in_ready_m, (mon_words < 2));
      chk("in_ready_lsb", in_ready_l, (mon_words < 2));
      chk("out_valid_msb", out_valid_m, (exp_q.size() != 0));
      chk("out_valid_lsb", out_valid_l, (exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("dout_msb", dout_m, exp_q[0].m);
        chk("dout_lsb", dout_l, exp_q[0].l);
        chk("last_msb", out_last_m, exp_q[0].last);
        chk("last_lsb", out_last_l, exp_q[0].last);
      end
      if (out_valid_m && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready_m) begin
        for (int k = 0; k < N; k++) begin
          mon_b.m    = 8'(din >> (8 * (N - 1 - k)));
          mon_b.l    = 8'(din >> (8 * k));
          mon_b.last = (k == N - 1);
          exp_q.push_back(mon_b);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge pclk);
    chk("rst_out_valid", {out_valid_m, out_valid_l}, 2'b00);
    chk("rst_dout", {dout_m, dout_l}, 16'h0000);
    chk("rst_last", {out_last_m, out_last_l}, 2'b00);
    chk("rst_in_ready", {in_ready_m, in_ready_l}, 2'b00);
    #2 rst = 1'b0;
    @(negedge pclk);
    chk("post_rst_in_ready", {in_ready_m, in_ready_l}, 2'b11);

    // Single word, both beat orders
    cyc();
    din = 40'h1255667890; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge pclk);
      expect_beat("single", e1m[k], e1l[k], (k == 4));
    end
    @(negedge pclk);
    chk("single_end_valid", {out_valid_m, out_valid_l}, 2'b00);

    // Back-to-back words with no gap
    cyc();
    din = 40'h0102030405; in_valid = 1'b1;
    cyc();
    din = 40'hA1A2A3A4A5;
    @(negedge pclk);
    expect_beat("b2b", e2m[0], e2l[0], 1'b0);
    cyc();
    in_valid = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge pclk);
      expect_beat("b2b", e2m[k], e2l[k], (k == 4 || k == 9));
      if (k == 1) chk("b2b_hr_full", {in_ready_m, in_ready_l}, 2'b00);
    end
    @(negedge pclk);
    chk("b2b_end_valid", {out_valid_m, out_valid_l}, 2'b00);

    // Backpressure for 3 cycles on beat 0x66 while a second word fills HR
    cyc();
    din = 40'h1255667890; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    @(negedge pclk);
    expect_beat("bp", e1m[0], e1l[0], 1'b0);
    @(negedge pclk);
    expect_beat("bp", e1m[1], e1l[1], 1'b0);
    cyc();
    out_ready = 1'b0; din = 40'hC1C2C3C4C5; in_valid = 1'b1;
    @(negedge pclk);
    expect_beat("bp_hold0", 8'h66, 8'h66, 1'b0);
    cyc();
    in_valid = 1'b0;
    @(negedge pclk);
    expect_beat("bp_hold1", 8'h66, 8'h66, 1'b0);
    chk("bp_in_ready", {in_ready_m, in_ready_l}, 2'b00);
    cyc();
    @(negedge pclk);
    expect_beat("bp_hold2", 8'h66, 8'h66, 1'b0);
    cyc();
    out_ready = 1'b1;
    @(negedge pclk);
    expect_beat("bp_hold3", 8'h66, 8'h66, 1'b0);
    @(negedge pclk);
    expect_beat("bp_resume", 8'h78, 8'h55, 1'b0);
    drain("bp");

    // Half-cycle reset while beat 0x66 is showing and HR is full
    cyc();
    din = 40'h1255667890; in_valid = 1'b1;
    cyc();
    din = 40'hB1B2B3B4B5;
    cyc();
    in_valid = 1'b0;
    @(negedge pclk);
    expect_beat("mrst", 8'h55, 8'h78, 1'b0);
    @(negedge pclk);
    expect_beat("mrst", 8'h66, 8'h66, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", {out_valid_m, out_valid_l}, 2'b00);
    chk("mrst_dout", {dout_m, dout_l}, 16'h0000);
    chk("mrst_last", {out_last_m, out_last_l}, 2'b00);
    chk("mrst_in_ready", {in_ready_m, in_ready_l}, 2'b00);
    exp_q.delete();
    #1 rst = 1'b0;
    @(negedge pclk);
    chk("mrst_after_in_ready", {in_ready_m, in_ready_l}, 2'b11);
    for (int k = 0; k < 6; k++) begin
      @(negedge pclk);
      chk("mrst_no_resume", {out_valid_m, out_valid_l}, 2'b00);
    end

    // Random traffic with occasional mid-cycle resets
    for (int c = 0; c < 4000; c++) begin
      cyc();
      in_valid  = ($urandom_range(0, 99) < 60);
      din       = {8'($urandom()), $urandom()};
      out_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #1 exp_q.delete();
        #1 rst = 1'b0;
      end
    end
    cyc();
    in_valid = 1'b0; out_ready = 1'b1;
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
